// File: rtl/icache_pkg.sv
// icache_pkg: shared types and address-slicing constants for fetch_icache.
//   icache_state_t : fill/response controller states
//   icache_line_t  : line layout (valid, tag, two words) at the default geometry
//   WORD_SEL_BIT / INDEX_LSB / tag_lsb() : fetch address field positions
package icache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL_REQ,
    S_FILL_WAIT,
    S_FILL_ACK,
    S_RESPOND
  } icache_state_t;

  // Fetch address layout: [tag | index | word]
  localparam int WORD_SEL_BIT = 0;
  localparam int INDEX_LSB    = 1;

  function automatic int tag_lsb(input int index_bits);
    return index_bits + 1;
  endfunction

  localparam int DEF_ADDR_BITS  = 8;
  localparam int DEF_DATA_BITS  = 16;
  localparam int DEF_INDEX_BITS = 4;
  localparam int DEF_TAG_BITS   = DEF_ADDR_BITS - DEF_INDEX_BITS - 1;

  typedef struct packed {
    logic                           valid;
    logic [DEF_TAG_BITS-1:0]        tag;
    logic [1:0][DEF_DATA_BITS-1:0]  data;
  } icache_line_t;

endpackage

// File: rtl/icache_line_store.sv
// icache_line_store: 2^INDEX_BITS line array for fetch_icache.
//   rd_idx -> rd_valid/rd_tag/rd_data : combinational read port
//   wr_en/wr_idx/wr_tag/wr_data       : write port, sets the line valid
//   clr                               : synchronous invalidate of every line
//   reset                             : async active-low, clears valid bits only
module icache_line_store #(
  parameter int INDEX_BITS = 4,
  parameter int TAG_BITS   = 3,
  parameter int DATA_BITS  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [INDEX_BITS-1:0]         rd_idx,
  output logic                          rd_valid,
  output logic [TAG_BITS-1:0]           rd_tag,
  output logic [1:0][DATA_BITS-1:0]     rd_data,
  input  logic                          wr_en,
  input  logic [INDEX_BITS-1:0]         wr_idx,
  input  logic [TAG_BITS-1:0]           wr_tag,
  input  logic [1:0][DATA_BITS-1:0]     wr_data,
  input  logic                          clr
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]                     valid_q;
  logic [LINES-1:0][TAG_BITS-1:0]       tag_q;
  logic [LINES-1:0][1:0][DATA_BITS-1:0] data_q;

  // Clear wins over a write; the controller never asks for both at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      valid_q <= '0;
    else if (clr)    valid_q <= '0;
    else if (wr_en)  valid_q[wr_idx] <= 1'b1;
  end

  // Payload needs no reset: it is only observed behind a set valid bit.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/fetch_icache.sv
// fetch_icache: direct-mapped read-only instruction cache, two-word lines.
//   fetch_read_*  : four-phase fetcher port (valid/address in, ready/data out)
//   mem_read_*    : four-phase program-memory consumer port (valid/address out)
//   flush         : pulse, invalidates all lines once no fill/response is live
//   hit_count / miss_count : saturating event counters, cleared only by reset
// ADDR_BITS must be at least 6.
module fetch_icache
  import icache_pkg::*;
#(
  parameter int ADDR_BITS  = 8,
  parameter int DATA_BITS  = 16,
  parameter int INDEX_BITS = 4,
  parameter int CNT_BITS   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fetch_read_valid,
  input  logic [ADDR_BITS-1:0] fetch_read_address,
  output logic                 fetch_read_ready,
  output logic [DATA_BITS-1:0] fetch_read_data,
  output logic                 mem_read_valid,
  output logic [ADDR_BITS-1:0] mem_read_address,
  input  logic                 mem_read_ready,
  input  logic [DATA_BITS-1:0] mem_read_data,
  input  logic                 flush,
  output logic [CNT_BITS-1:0]  hit_count,
  output logic [CNT_BITS-1:0]  miss_count
);

  localparam int TAG_LSB  = tag_lsb(INDEX_BITS);
  localparam int TAG_BITS = ADDR_BITS - TAG_LSB;

  icache_state_t               state;
  logic [ADDR_BITS-1:0]        fill_addr;
  logic                        word_cnt;
  logic [1:0][DATA_BITS-1:0]   fill_buf;
  logic                        flush_pending;

  logic                        rd_valid;
  logic [TAG_BITS-1:0]         rd_tag;
  logic [1:0][DATA_BITS-1:0]   rd_data;
  logic                        hit;
  logic                        fill_done;
  logic                        resp_done;
  logic                        clr;

  assign hit       = rd_valid && (rd_tag == fetch_read_address[ADDR_BITS-1:TAG_LSB]);
  assign fill_done = (state == S_FILL_ACK) && !mem_read_ready && word_cnt;
  assign resp_done = (state == S_RESPOND) && !fetch_read_valid;
  // Invalidate on the edge back into IDLE, or in IDLE when no lookup is taken.
  // A lookup in the flush cycle sees the old contents; the flush then waits
  // pending until its response retires.
  assign clr = (flush || flush_pending) &&
               (resp_done || ((state == S_IDLE) && !fetch_read_valid));

  icache_line_store #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS),
    .DATA_BITS  (DATA_BITS)
  ) u_store (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (fetch_read_address[INDEX_BITS:INDEX_LSB]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (fill_done),
    .wr_idx   (fill_addr[INDEX_BITS:INDEX_LSB]),
    .wr_tag   (fill_addr[ADDR_BITS-1:TAG_LSB]),
    .wr_data  (fill_buf),
    .clr      (clr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= S_IDLE;
      fill_addr        <= '0;
      word_cnt         <= 1'b0;
      fill_buf         <= '0;
      flush_pending    <= 1'b0;
      fetch_read_ready <= 1'b0;
      fetch_read_data  <= '0;
      mem_read_valid   <= 1'b0;
      mem_read_address <= '0;
      hit_count        <= '0;
      miss_count       <= '0;
    end else begin
      flush_pending <= clr ? 1'b0 : (flush_pending || flush);
      case (state)
        S_IDLE: begin
          if (fetch_read_valid) begin
            if (hit) begin
              fetch_read_data  <= rd_data[fetch_read_address[WORD_SEL_BIT]];
              fetch_read_ready <= 1'b1;
              if (hit_count != '1) hit_count <= hit_count + 1'b1;
              state            <= S_RESPOND;
            end else begin
              fill_addr <= fetch_read_address;
              word_cnt  <= 1'b0;
              if (miss_count != '1) miss_count <= miss_count + 1'b1;
              state     <= S_FILL_REQ;
            end
          end
        end
        S_FILL_REQ: begin
          mem_read_valid   <= 1'b1;
          mem_read_address <= {fill_addr[ADDR_BITS-1:1], word_cnt};
          state            <= S_FILL_WAIT;
        end
        S_FILL_WAIT: begin
          if (mem_read_ready) begin
            fill_buf[word_cnt] <= mem_read_data;
            mem_read_valid     <= 1'b0;
            state              <= S_FILL_ACK;
          end
        end
        S_FILL_ACK: begin
          // Next request only after the controller has dropped ready.
          if (!mem_read_ready) begin
            if (!word_cnt) begin
              word_cnt <= 1'b1;
              state    <= S_FILL_REQ;
            end else begin
              fetch_read_data  <= fill_buf[fill_addr[WORD_SEL_BIT]];
              fetch_read_ready <= 1'b1;
              state            <= S_RESPOND;
            end
          end
        end
        S_RESPOND: begin
          if (!fetch_read_valid) begin
            fetch_read_ready <= 1'b0;
            state            <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_icache.sv
// tb_fetch_icache: directed stimulus with a response/memory-address scoreboard.
// A second instance with 2-bit counters shares all inputs to exercise saturation.
module tb_fetch_icache;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fv;
  logic [7:0]  fa;
  logic        fr, fr2;
  logic [15:0] fd, fd2;
  logic        mv, mv2;
  logic [7:0]  ma, ma2;
  logic        mr;
  logic [15:0] md;
  logic        flush;
  logic [15:0] hc, mc;
  logic [1:0]  hc2, mc2;

  always #5 clk = ~clk;

  fetch_icache dut (
    .clk(clk), .reset(reset),
    .fetch_read_valid(fv), .fetch_read_address(fa),
    .fetch_read_ready(fr), .fetch_read_data(fd),
    .mem_read_valid(mv), .mem_read_address(ma),
    .mem_read_ready(mr), .mem_read_data(md),
    .flush(flush), .hit_count(hc), .miss_count(mc)
  );

  fetch_icache #(.CNT_BITS(2)) dut2 (
    .clk(clk), .reset(reset),
    .fetch_read_valid(fv), .fetch_read_address(fa),
    .fetch_read_ready(fr2), .fetch_read_data(fd2),
    .mem_read_valid(mv2), .mem_read_address(ma2),
    .mem_read_ready(mr), .mem_read_data(md),
    .flush(flush), .hit_count(hc2), .miss_count(mc2)
  );

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_data[$];
  logic [7:0]  exp_maddr[$];
  logic [15:0] mem [0:255];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory responder: four-phase, LAT negedges to ready, holds until valid drops.
  initial begin
    mr = 1'b0;
    md = '0;
    forever begin
      @(negedge clk);
      if (mv && !mr) begin
        repeat (LAT - 1) @(negedge clk);
        if (mv && reset) begin
          md = mem[ma];
          mr = 1'b1;
          for (int n = 0; n < 100 && mv; n++) @(negedge clk);
          mr = 1'b0;
        end
      end
    end
  end

  // Memory-request monitor
  logic mv_prev = 1'b0;
  always @(negedge clk) begin
    if (mv && !mv_prev) begin
      if (exp_maddr.size() == 0) begin
        tests++; fails++;
        $display("FAIL mem_unexpected: got request at 0x%0h expected none", ma);
      end else begin
        chk("mem_addr", {24'd0, ma}, {24'd0, exp_maddr.pop_front()});
      end
    end
    mv_prev = mv;
  end

  // Fetch-response monitor
  logic fr_prev = 1'b0;
  always @(negedge clk) begin
    if (fr && !fr_prev) begin
      if (exp_data.size() == 0) begin
        tests++; fails++;
        $display("FAIL fetch_unexpected: got data 0x%0h expected none", fd);
      end else begin
        chk("fetch_data", {16'd0, fd}, {16'd0, exp_data.pop_front()});
      end
    end
    fr_prev = fr;
  end

  task automatic do_fetch(input logic [7:0] addr, input logic [15:0] exp,
                          input bit is_hit, input bit with_flush);
    int n;
    exp_data.push_back(exp);
    if (!is_hit) begin
      exp_maddr.push_back({addr[7:1], 1'b0});
      exp_maddr.push_back({addr[7:1], 1'b1});
    end
    @(negedge clk);
    fa = addr;
    fv = 1'b1;
    if (with_flush) flush = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      if (with_flush) flush = 1'b0;
      n++;
    end while (!fr && n < 200);
    if (!fr) chk("fetch_timeout", 32'd0, 32'd1);
    else if (is_hit) chk("hit_latency", n, 1);
    fv = 1'b0;
    n = 0;
    while (fr && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("ready_drop", {31'd0, fr}, 32'd0);
  endtask

  initial begin
    int n;
    fv = 1'b0; fa = '0; flush = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h5000 | 16'(i);
    mem[8'h12] = 16'hA001; mem[8'h13] = 16'hA002;
    mem[8'h32] = 16'hB001; mem[8'h33] = 16'hB002;
    mem[8'h40] = 16'hC001; mem[8'h41] = 16'hC002;

    repeat (3) @(negedge clk);
    chk("rst_fetch_ready", {31'd0, fr}, 32'd0);
    chk("rst_fetch_data",  {16'd0, fd}, 32'd0);
    chk("rst_mem_valid",   {31'd0, mv}, 32'd0);
    chk("rst_mem_addr",    {24'd0, ma}, 32'd0);
    chk("rst_hit_count",   {16'd0, hc}, 32'd0);
    chk("rst_miss_count",  {16'd0, mc}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    do_fetch(8'h12, 16'hA001, 0, 0);          // cold miss
    chk("miss_after_cold", {16'd0, mc}, 32'd1);
    chk("hit_after_cold",  {16'd0, hc}, 32'd0);
    do_fetch(8'h13, 16'hA002, 1, 0);          // same line hit
    chk("hit_after_13",    {16'd0, hc}, 32'd1);
    do_fetch(8'h32, 16'hB001, 0, 0);          // conflict, index 9
    do_fetch(8'h12, 16'hA001, 0, 0);          // evicted, misses again
    chk("miss_after_conflict", {16'd0, mc}, 32'd3);

    do_fetch(8'h13, 16'hA002, 1, 1);          // flush with lookup: pre-flush hit
    chk("hit_flush_same_cycle", {16'd0, hc}, 32'd2);
    do_fetch(8'h13, 16'hA002, 0, 0);          // flush took effect afterwards
    chk("miss_after_flush", {16'd0, mc}, 32'd4);

    fork                                      // flush mid-fill
      do_fetch(8'h40, 16'hC001, 0, 0);
      begin
        n = 0;
        while (!mv && n < 50) begin @(negedge clk); n++; end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
      end
    join
    do_fetch(8'h40, 16'hC001, 0, 0);
    chk("miss_after_midfill_flush", {16'd0, mc}, 32'd6);
    do_fetch(8'h41, 16'hC002, 1, 0);

    @(negedge clk); flush = 1'b1;             // idle flush
    @(negedge clk); flush = 1'b0;
    do_fetch(8'h41, 16'hC002, 0, 0);
    chk("miss_after_idle_flush", {16'd0, mc}, 32'd7);

    do_fetch(8'h40, 16'hC001, 1, 0);
    do_fetch(8'h41, 16'hC002, 1, 0);
    do_fetch(8'h40, 16'hC001, 1, 0);
    chk("hit_count_wide", {16'd0, hc},  32'd6);
    chk("hit_count_sat",  {30'd0, hc2}, 32'd3);
    chk("miss_count_sat", {30'd0, mc2}, 32'd3);

    // reset during FILL_WAIT
    exp_maddr.push_back(8'h50);
    @(negedge clk);
    fa = 8'h50; fv = 1'b1;
    n = 0;
    while (!mv && n < 50) begin @(negedge clk); n++; end
    chk("reach_fill_wait", {31'd0, mv}, 32'd1);
    reset = 1'b0;
    #1;
    chk("midfill_rst_mem_valid",   {31'd0, mv}, 32'd0);
    chk("midfill_rst_fetch_ready", {31'd0, fr}, 32'd0);
    chk("midfill_rst_hit_count",   {16'd0, hc}, 32'd0);
    chk("midfill_rst_miss_count",  {16'd0, mc}, 32'd0);
    fv = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    do_fetch(8'h12, 16'hA001, 0, 0);
    chk("miss_after_reset", {16'd0, mc}, 32'd1);
    chk("hit_after_reset",  {16'd0, hc}, 32'd0);

    repeat (3) @(negedge clk);
    chk("data_queue_empty",  exp_data.size(),  32'd0);
    chk("maddr_queue_empty", exp_maddr.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
